morse_encoder_param: RTL and testbench

MORSE_ENCODER_PARAM -- requirements
Module: morse_encoder_param

---
 rtl/morse_pkg.sv | 34 +++
 rtl/morse_rom.sv | 52 +++++
 rtl/morse_encoder_param.sv | 178 +++++++++++++++++
 tb/tb_morse_encoder_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_pkg
//  Purpose  : Shared definitions for the Morse encoder: output symbol codes,
//             FSM state encoding and letter-code constants.
//  Revision : 1.0  initial release
// ============================================================================
package morse_pkg;

    // Symbol codes driven on Morse (2'h3 is never produced)
    localparam logic [1:0] GAP  = 2'h0;
    localparam logic [1:0] DOT  = 2'h1;
    localparam logic [1:0] DASH = 2'h2;

    // Letter codes: 0..25 = A..Z, 26 = word space, 27..31 = invalid
    localparam logic [4:0] LTR_LAST  = 5'd25;
    localparam logic [4:0] LTR_SPACE = 5'd26;

    // FSM state encoding; the code is visible on OutState
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_EGAP = 3'd2,
        ST_LGAP = 3'd3,
        ST_WGAP = 3'd4
    } state_t;

    // Symbol for one pattern bit (1 = dash)
    function automatic logic [1:0] element_symbol(input logic is_dash);
        return is_dash ? DASH : DOT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_rom.sv
`default_nettype none
// ============================================================================
//  Module   : morse_rom
//  Purpose  : Combinational A-Z Morse lookup table.
//  Ports    : Letter  [4:0] in  - letter code (0..25 = A..Z)
//             length  [2:0] out - element count 1..4 (0 for non-letters)
//             pattern [3:0] out - elements left-aligned, MSB first,
//                                 1 = dash, unused low bits are 0
//  Revision : 1.0  initial release
// ============================================================================
module morse_rom (
    input  logic [4:0] Letter,
    output logic [2:0] length,
    output logic [3:0] pattern
);

    always_comb begin
        length  = 3'd0;
        pattern = 4'b0000;
        case (Letter)
            5'd0:  begin length = 3'd2; pattern = 4'b0100; end // A .-
            5'd1:  begin length = 3'd4; pattern = 4'b1000; end // B -...
            5'd2:  begin length = 3'd4; pattern = 4'b1010; end // C -.-.
            5'd3:  begin length = 3'd3; pattern = 4'b1000; end // D -..
            5'd4:  begin length = 3'd1; pattern = 4'b0000; end // E .
            5'd5:  begin length = 3'd4; pattern = 4'b0010; end // F ..-.
            5'd6:  begin length = 3'd3; pattern = 4'b1100; end // G --.
            5'd7:  begin length = 3'd4; pattern = 4'b0000; end // H ....
            5'd8:  begin length = 3'd2; pattern = 4'b0000; end // I ..
            5'd9:  begin length = 3'd4; pattern = 4'b0111; end // J .---
            5'd10: begin length = 3'd3; pattern = 4'b1010; end // K -.-
            5'd11: begin length = 3'd4; pattern = 4'b0100; end // L .-..
            5'd12: begin length = 3'd2; pattern = 4'b1100; end // M --
            5'd13: begin length = 3'd2; pattern = 4'b1000; end // N -.
            5'd14: begin length = 3'd3; pattern = 4'b1110; end // O ---
            5'd15: begin length = 3'd4; pattern = 4'b0110; end // P .--.
            5'd16: begin length = 3'd4; pattern = 4'b1101; end // Q --.-
            5'd17: begin length = 3'd3; pattern = 4'b0100; end // R .-.
            5'd18: begin length = 3'd3; pattern = 4'b0000; end // S ...
            5'd19: begin length = 3'd1; pattern = 4'b1000; end // T -
            5'd20: begin length = 3'd3; pattern = 4'b0010; end // U ..-
            5'd21: begin length = 3'd4; pattern = 4'b0001; end // V ...-
            5'd22: begin length = 3'd3; pattern = 4'b0110; end // W .--
            5'd23: begin length = 3'd4; pattern = 4'b1001; end // X -..-
            5'd24: begin length = 3'd4; pattern = 4'b1011; end // Y -.--
            5'd25: begin length = 3'd4; pattern = 4'b1100; end // Z --..
            default: begin length = 3'd0; pattern = 4'b0000; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : morse_encoder_param
//  Purpose  : Parameterised letter-to-Morse encoder. Accepts one letter code
//             per handshake and plays its dots/dashes with element, letter
//             and word gaps, all timed in units of UNIT_CYCLES clocks.
//  Ports    : Clock        in      rising-edge clock
//             Reset        in      synchronous, active-high
//             Letter [4:0] in      0..25 = A..Z, 26 = space, 27..31 invalid
//             LetterValid  in      Letter is presented
//             LetterReady  out     encoder can accept (IDLE only)
//             Morse  [1:0] out     0 gap, 1 dot, 2 dash
//             Busy         out     inverse of LetterReady
//             BadLetter    out     one-cycle pulse on accepted invalid code
//             OutState [2:0] out   current FSM state code
//  Revision : 1.0  initial release
// ============================================================================
module morse_encoder_param
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = 1,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [4:0] Letter,
    input  logic       LetterValid,
    output logic       LetterReady,
    output logic [1:0] Morse,
    output logic       Busy,
    output logic       BadLetter,
    output logic [2:0] OutState
);

    // Duration counter is sized for the longest interval so it never wraps.
    localparam int c_max_units  = (DASH_UNITS > LETTER_GAP_UNITS)
                                ? ((DASH_UNITS > WORD_GAP_UNITS) ? DASH_UNITS : WORD_GAP_UNITS)
                                : ((LETTER_GAP_UNITS > WORD_GAP_UNITS) ? LETTER_GAP_UNITS : WORD_GAP_UNITS);
    localparam int c_max_cycles = c_max_units * UNIT_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles < 1) ? 1 : $clog2(c_max_cycles + 1);

    // The counter is loaded with (duration - 1) and the state ends at zero.
    localparam logic [c_cnt_w-1:0] c_dot_last    = c_cnt_w'(UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_dash_last   = c_cnt_w'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_letter_last = c_cnt_w'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_word_last   = c_cnt_w'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_pat;     // current element always in bit 3
    logic [2:0]         r_rem;     // elements still to play after the current one
    logic [1:0]         r_morse;
    logic               r_ready;
    logic               r_busy;
    logic               r_bad;

    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [3:0]         w_pat_nxt;
    logic [2:0]         w_rem_nxt;
    logic               w_bad_nxt;
    logic [1:0]         w_morse_nxt;
    logic [2:0]         w_rom_len;
    logic [3:0]         w_rom_pat;
    logic               w_cnt_done;

    morse_rom u_rom (
        .Letter  (Letter),
        .length  (w_rom_len),
        .pattern (w_rom_pat)
    );

    assign w_cnt_done = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pat_nxt   = r_pat;
        w_rem_nxt   = r_rem;
        w_bad_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (LetterValid) begin
                    if (Letter <= LTR_LAST) begin
                        w_state_nxt = ST_MARK;
                        w_pat_nxt   = w_rom_pat;
                        w_rem_nxt   = w_rom_len - 3'd1;
                        w_cnt_nxt   = w_rom_pat[3] ? c_dash_last : c_dot_last;
                    end else if (Letter == LTR_SPACE) begin
                        w_state_nxt = ST_WGAP;
                        w_cnt_nxt   = c_word_last;
                    end else begin
                        // Invalid code is consumed but produces no symbols.
                        w_bad_nxt = 1'b1;
                    end
                end
            end

            ST_MARK: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_rem != 3'd0) begin
                    w_state_nxt = ST_EGAP;
                    w_cnt_nxt   = c_dot_last;
                end else begin
                    w_state_nxt = ST_LGAP;
                    w_cnt_nxt   = c_letter_last;
                end
            end

            ST_EGAP: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Advance to the next element; r_pat[2] becomes the new bit 3.
                    w_state_nxt = ST_MARK;
                    w_pat_nxt   = {r_pat[2:0], 1'b0};
                    w_rem_nxt   = r_rem - 3'd1;
                    w_cnt_nxt   = r_pat[2] ? c_dash_last : c_dot_last;
                end
            end

            ST_LGAP, ST_WGAP: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_pat_nxt   = 4'b0000;
                    w_rem_nxt   = 3'd0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_pat_nxt   = 4'b0000;
                w_rem_nxt   = 3'd0;
            end
        endcase

        // Outputs are precomputed from next-state so they can be registered.
        w_morse_nxt = (w_state_nxt == ST_MARK) ? element_symbol(w_pat_nxt[3]) : GAP;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pat   <= 4'b0000;
            r_rem   <= 3'd0;
            r_morse <= GAP;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pat   <= w_pat_nxt;
            r_rem   <= w_rem_nxt;
            r_morse <= w_morse_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_bad   <= w_bad_nxt;
        end
    end

    assign LetterReady = r_ready;
    assign Busy        = r_busy;
    assign Morse       = r_morse;
    assign BadLetter   = r_bad;
    assign OutState    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_encoder_param
//  Purpose  : Scoreboard bench for morse_encoder_param. Two instances
//             (UNIT_CYCLES = 1 and 3) each get a directed opening sequence
//             followed by random letters, held/ignored valids and resets.
//             A reference model expands each accepted letter into its
//             per-cycle expected outputs from the Morse alphabet.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_encoder_param;

    localparam int c_dash_units = 3;
    localparam int c_lgap_units = 3;
    localparam int c_wgap_units = 7;
    localparam int c_cycles     = 3000;

    typedef struct packed {
        logic [1:0] m;
        logic       rdy;
        logic       bad;
        logic [2:0] st;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, v0, rdy0, busy0, bad0;
    logic [4:0] l0;
    logic [1:0] m0;
    logic [2:0] st0;
    logic       rst1, v1, rdy1, busy1, bad1;
    logic [4:0] l1;
    logic [1:0] m1;
    logic [2:0] st1;

    morse_encoder_param #(
        .UNIT_CYCLES(1), .DASH_UNITS(c_dash_units),
        .LETTER_GAP_UNITS(c_lgap_units), .WORD_GAP_UNITS(c_wgap_units)
    ) u_dut0 (
        .Clock(clk), .Reset(rst0), .Letter(l0), .LetterValid(v0),
        .LetterReady(rdy0), .Morse(m0), .Busy(busy0), .BadLetter(bad0),
        .OutState(st0)
    );

    morse_encoder_param #(
        .UNIT_CYCLES(3), .DASH_UNITS(c_dash_units),
        .LETTER_GAP_UNITS(c_lgap_units), .WORD_GAP_UNITS(c_wgap_units)
    ) u_dut1 (
        .Clock(clk), .Reset(rst1), .Letter(l1), .LetterValid(v1),
        .LetterReady(rdy1), .Morse(m1), .Busy(busy1), .BadLetter(bad1),
        .OutState(st1)
    );

    string code_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                             "....", "..", ".---", "-.-", ".-..", "--", "-.",
                             "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                             "...-", ".--", "-..-", "-.--", "--.."};

    rec_t q0[$];
    rec_t q1[$];
    int   vectors  = 0;
    int   errors   = 0;
    bit   run0     = 1'b0;
    bit   run1     = 1'b0;

    function automatic rec_t mk(input logic [1:0] m, input logic rdy,
                                input logic bad, input logic [2:0] st);
        rec_t r;
        r.m = m; r.rdy = rdy; r.bad = bad; r.st = st;
        return r;
    endfunction

    task automatic push(input int idx, input rec_t r);
        if (idx == 0) q0.push_back(r);
        else          q1.push_back(r);
    endtask

    // Drop everything scheduled after the current cycle.
    task automatic flush_future(input int idx);
        if (idx == 0) begin
            while (q0.size() > 1) void'(q0.pop_back());
        end else begin
            while (q1.size() > 1) void'(q1.pop_back());
        end
    endtask

    task automatic drive(input int idx, input logic r, input logic v, input logic [4:0] l);
        if (idx == 0) begin rst0 = r; v0 = v; l0 = l; end
        else          begin rst1 = r; v1 = v; l1 = l; end
    endtask

    // Reference model: expected outputs for every cycle of a letter/space.
    task automatic push_trace(input int idx, input int unit, input int letter, output int n);
        string s;
        n = 0;
        if (letter == 26) begin
            repeat (c_wgap_units * unit) begin push(idx, mk(2'd0, 1'b0, 1'b0, 3'd4)); n++; end
        end else begin
            s = code_tbl[letter];
            for (int i = 0; i < s.len(); i++) begin
                bit is_dash = (s.getc(i) == "-");
                repeat (is_dash ? c_dash_units * unit : unit) begin
                    push(idx, mk(is_dash ? 2'd2 : 2'd1, 1'b0, 1'b0, 3'd1)); n++;
                end
                if (i != s.len() - 1) begin
                    repeat (unit) begin push(idx, mk(2'd0, 1'b0, 1'b0, 3'd2)); n++; end
                end
            end
            repeat (c_lgap_units * unit) begin push(idx, mk(2'd0, 1'b0, 1'b0, 3'd3)); n++; end
        end
    endtask

    function automatic int pick_letter();
        int r = $urandom_range(0, 19);
        if (r < 16)      return $urandom_range(0, 25);
        else if (r < 18) return 26;
        else             return $urandom_range(27, 31);
    endfunction

    task automatic run_driver(input int idx, input int unit);
        int idle_at  = 0;
        bit bad_pend = 1'b0;
        int rst_at   = -1;
        int dir_i    = 0;
        int dir_letter[$];
        int dir_rst[$];
        int n;
        if (idx == 0) begin
            // A, O, space+E held, invalid 30, L with reset mid-dash, then E
            dir_letter = '{0, 14, 26, 4, 30, 11, 4};
            dir_rst    = '{-1, -1, -1, -1, -1, 3, -1};
        end else begin
            dir_letter = '{4, 26, 4};
            dir_rst    = '{-1, -1, -1};
        end
        drive(idx, 1'b1, 1'b0, 5'd0);
        @(posedge clk); #1;
        if (idx == 0) run0 = 1'b1; else run1 = 1'b1;
        for (int cyc = 0; cyc < c_cycles; cyc++) begin
            bit idle = (cyc >= idle_at);
            bit do_rst;
            bit v;
            int l;
            if (idle) begin
                push(idx, mk(2'd0, 1'b1, bad_pend, 3'd0));
                bad_pend = 1'b0;
            end
            do_rst = (cyc < 2) || (cyc == rst_at) ||
                     (dir_i >= dir_letter.size() && $urandom_range(0, 149) == 0);
            if (do_rst) begin
                flush_future(idx);
                idle_at  = cyc + 1;
                bad_pend = 1'b0;
                rst_at   = -1;
                drive(idx, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom));
            end else if (idle) begin
                if (dir_i < dir_letter.size()) begin
                    v = 1'b1;
                    l = dir_letter[dir_i];
                    if (dir_rst[dir_i] >= 0) rst_at = cyc + dir_rst[dir_i];
                    dir_i++;
                end else begin
                    v = ($urandom_range(0, 3) != 0);
                    l = pick_letter();
                end
                if (v && l <= 26) begin
                    push_trace(idx, unit, l, n);
                    idle_at = cyc + 1 + n;
                end else begin
                    if (v) bad_pend = 1'b1;
                    idle_at = cyc + 1;
                end
                drive(idx, 1'b0, v, 5'(l));
            end else if (dir_i < dir_letter.size()) begin
                // hold the next directed letter valid while busy
                drive(idx, 1'b0, 1'b1, 5'(dir_letter[dir_i]));
            end else begin
                drive(idx, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom));
            end
            @(posedge clk); #1;
        end
        if (idx == 0) run0 = 1'b0; else run1 = 1'b0;
        drive(idx, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic check(input int idx, input rec_t act, input logic busy_act);
        rec_t e;
        bit   empty = 1'b0;
        if (idx == 0) begin
            if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
        end else begin
            if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
        end
        vectors++;
        if (empty) begin
            errors++;
            $display("FAIL inst%0d scoreboard_empty at t=%0t: got morse=%0d, required an expectation",
                     idx, $time, act.m);
        end else if (act !== e || busy_act !== ~e.rdy) begin
            errors++;
            $display("FAIL inst%0d outputs t=%0t: got morse=%0d rdy=%b bad=%b st=%0d busy=%b, required morse=%0d rdy=%b bad=%b st=%0d busy=%b",
                     idx, $time, act.m, act.rdy, act.bad, act.st, busy_act,
                     e.m, e.rdy, e.bad, e.st, ~e.rdy);
        end
    endtask

    always @(negedge clk) begin
        if (run0) check(0, mk(m0, rdy0, bad0, st0), busy0);
        if (run1) check(1, mk(m1, rdy1, bad1, st1), busy1);
    end

    initial begin
        drive(0, 1'b1, 1'b0, 5'd0);
        drive(1, 1'b1, 1'b0, 5'd0);
        fork
            run_driver(0, 1);
            run_driver(1, 3);
        join
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
